// File: rtl/twpm_cmd_ctrl.sv
// TwPM command controller, wb_clk side: synchronises LPC-domain exec/abort, latches the command
// descriptor, raises irq_o and serves the Wishbone status/descriptor/complete registers.
// Define TWPM_WB_ERR_EN to signal unmapped accesses with wb_err_o instead of wb_ack_o.
module twpm_cmd_ctrl #(
  parameter int RAM_ADDR_WIDTH       = 11,
  parameter int COMPLETE_PULSE_WIDTH = 20,
  parameter int SYNC_STAGES          = 2
) (
  input  logic                      wb_clk,
  input  logic                      rstn_i,
  input  logic [16:0]               wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  input  logic                      wb_we_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_cyc_i,
  input  logic [3:0]                wb_sel_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  input  logic                      exec_i,
  input  logic                      abort_i,
  input  logic [3:0]                op_type_i,
  input  logic [3:0]                locality_i,
  input  logic [RAM_ADDR_WIDTH-1:0] buf_len_i,
  input  logic [31:0]               ram_rd_i,
  output logic [3:0]                ram_wen_o,
  output logic                      cpu_owns_ram_o,
  output logic                      complete_o,
  output logic                      irq_o
);

  localparam logic [14:0] ADR_STATUS   = 15'h000;
  localparam logic [14:0] ADR_OP_TYPE  = 15'h001;
  localparam logic [14:0] ADR_LOCALITY = 15'h002;
  localparam logic [14:0] ADR_BUF_SIZE = 15'h003;
  localparam logic [14:0] ADR_IRQ_CTRL = 15'h004;
  localparam logic [14:0] ADR_COMPLETE = 15'h010;
  localparam logic [7:0]  PULSE_LEN    = 8'(COMPLETE_PULSE_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_ABORTED = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                    state_reg, state_next;
  logic [SYNC_STAGES-1:0]    exec_sync_reg, abort_sync_reg;
  logic                      exec_d_reg;
  logic [7:0]                cnt_reg;
  logic                      pending_reg, enable_reg, ack_reg;
  logic [3:0]                op_type_reg, locality_reg;
  logic [RAM_ADDR_WIDTH-1:0] buf_len_reg;

  logic        exec_s, abort_s, exec_rise;
  logic [14:0] word_adr;
  logic        ram_hit, req, wr_req, complete_wr, irq_wr;
  logic        set_pending, load_desc, load_cnt;
  logic        unused_bits;

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:2]};

  // Plain flop chains; the last stage is the only one allowed to feed logic.
  always_ff @(posedge wb_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      exec_sync_reg  <= '0;
      abort_sync_reg <= '0;
      exec_d_reg     <= 1'b0;
    end else begin
      exec_sync_reg  <= {exec_sync_reg[SYNC_STAGES-2:0], exec_i};
      abort_sync_reg <= {abort_sync_reg[SYNC_STAGES-2:0], abort_i};
      exec_d_reg     <= exec_s;
    end
  end

  assign exec_s    = exec_sync_reg[SYNC_STAGES-1];
  assign abort_s   = abort_sync_reg[SYNC_STAGES-1];
  assign exec_rise = exec_s & ~exec_d_reg;

  assign word_adr = wb_adr_i[16:2];
  assign ram_hit  = (wb_adr_i[16:11] == 6'b000001);

`ifdef TWPM_WB_ERR_EN
  logic err_reg;
  logic mapped;

  assign mapped = ram_hit | (word_adr == ADR_STATUS) | (word_adr == ADR_OP_TYPE) |
                  (word_adr == ADR_LOCALITY) | (word_adr == ADR_BUF_SIZE) |
                  (word_adr == ADR_IRQ_CTRL) | (word_adr == ADR_COMPLETE);
  assign req    = wb_cyc_i & wb_stb_i & ~ack_reg & ~err_reg;

  always_ff @(posedge wb_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      ack_reg <= req & mapped;
      err_reg <= req & ~mapped;
    end
  end

  assign wb_err_o = err_reg;
`else
  assign req = wb_cyc_i & wb_stb_i & ~ack_reg;

  always_ff @(posedge wb_clk or negedge rstn_i) begin
    if (!rstn_i) ack_reg <= 1'b0;
    else         ack_reg <= req;
  end

  assign wb_err_o = 1'b0;
`endif

  assign wb_ack_o    = ack_reg;
  assign wr_req      = req & wb_we_i;
  assign complete_wr = wr_req & (word_adr == ADR_COMPLETE);
  assign irq_wr      = wr_req & (word_adr == ADR_IRQ_CTRL);

  always_ff @(posedge wb_clk or negedge rstn_i) begin
    if (!rstn_i) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (exec_rise) state_next = abort_s ? ST_ABORTED : ST_CMD;
      ST_CMD: begin
        if (abort_s)          state_next = ST_ABORTED;
        else if (complete_wr) state_next = ST_DONE;
        else if (!exec_s)     state_next = ST_IDLE;
      end
      ST_ABORTED: if (complete_wr) state_next = ST_DONE;
      ST_DONE:    if ((cnt_reg == 8'd0) && !exec_s) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    set_pending    = 1'b0;
    load_desc      = 1'b0;
    load_cnt       = 1'b0;
    cpu_owns_ram_o = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        set_pending = exec_rise;
        load_desc   = exec_rise;
      end
      ST_CMD: begin
        cpu_owns_ram_o = 1'b1;
        set_pending    = abort_s;
        load_cnt       = ~abort_s & complete_wr;
      end
      ST_ABORTED: begin
        cpu_owns_ram_o = 1'b1;
        load_cnt       = complete_wr;
      end
      ST_DONE:  cpu_owns_ram_o = 1'b1;
      default: ;
    endcase
  end

  // A new pending event outranks a simultaneous clear from the CPU.
  always_ff @(posedge wb_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_reg      <= 8'd0;
      pending_reg  <= 1'b0;
      enable_reg   <= 1'b0;
      op_type_reg  <= 4'd0;
      locality_reg <= 4'd0;
      buf_len_reg  <= '0;
    end else begin
      if (load_cnt)              cnt_reg <= PULSE_LEN;
      else if (cnt_reg != 8'd0)  cnt_reg <= cnt_reg - 8'd1;

      if (set_pending)                 pending_reg <= 1'b1;
      else if (irq_wr && wb_dat_i[1])  pending_reg <= 1'b0;

      if (irq_wr) enable_reg <= wb_dat_i[0];

      if (load_desc) begin
        op_type_reg  <= op_type_i;
        locality_reg <= locality_i;
        buf_len_reg  <= buf_len_i;
      end
    end
  end

  assign complete_o = (cnt_reg != 8'd0);
  assign irq_o      = pending_reg & enable_reg;
  assign ram_wen_o  = (ram_hit && wr_req && cpu_owns_ram_o) ? wb_sel_i : 4'b0000;

  always_comb begin
    wb_dat_o = 32'hBADFABAC;
    if (ram_hit) begin
      wb_dat_o = ram_rd_i;
    end else begin
      case (word_adr)
        ADR_STATUS:   wb_dat_o = {27'd0, pending_reg, (state_reg == ST_ABORTED),
                                  complete_o, abort_s, exec_s};
        ADR_OP_TYPE:  wb_dat_o = {28'd0, op_type_reg};
        ADR_LOCALITY: wb_dat_o = {28'd0, locality_reg};
        ADR_BUF_SIZE: wb_dat_o = {{(32-RAM_ADDR_WIDTH){1'b0}}, buf_len_reg};
        ADR_IRQ_CTRL: wb_dat_o = {30'd0, pending_reg, enable_reg};
        ADR_COMPLETE: wb_dat_o = 32'd0;
        default:      wb_dat_o = 32'hBADFABAC;
      endcase
    end
  end

endmodule
